// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell processes one bit pair per
// clock, with the carry loop closed through a flip-flop.

module full_adder (
    input  logic x,
    input  logic y,
    input  logic c_in,
    output logic s_out,
    output logic c_out
);
    logic p;

    assign p     = x ^ y;
    assign s_out = p ^ c_in;
    assign c_out = (x & y) | (c_in & p);
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, s_sr, s_nxt;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fa_s, fa_c;
    logic             load, last;

    full_adder u_fa (
        .x     (a_sr[0]),
        .y     (b_sr[0]),
        .c_in  (carry),
        .s_out (fa_s),
        .c_out (fa_c)
    );

    // Current sum bit enters at the MSB so the finished word lands LSB-aligned.
    always_comb begin
        s_nxt            = s_sr >> 1;
        s_nxt[WIDTH-1]   = fa_s;
    end

    assign last = (cnt == LAST);
    assign load = start && (state == IDLE || state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            c_out <= 1'b0;
        end else if (load) begin
            a_sr  <= a;
            b_sr  <= b;
            s_sr  <= '0;
            cnt   <= '0;
            carry <= c_in;
        end else if (state == RUN) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            s_sr  <= s_nxt;
            carry <= fa_c;
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum   <= s_nxt;
                c_out <= fa_c;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8 with hand-computed results.

module tb_serial_adder;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             c_in = 1'b0;
    logic             busy, done, c_out;
    logic [WIDTH-1:0] sum;

    int pass_cnt = 0;
    int total    = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Present an operation at a falling edge; it is accepted at the next rising edge.
    task automatic launch(input logic [7:0] va, input logic [7:0] vb, input logic vc);
        @(negedge clk);
        a = va; b = vb; c_in = vc; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Follow an accepted operation through RUN and DONE. inject>0 pulses start
    // with 0xFF+0xFF sampled at E(inject); chain holds start in the DONE cycle.
    task automatic track(input string tag,
                         input logic [7:0] prev_s, input logic prev_c,
                         input logic [7:0] exp_s,  input logic exp_c,
                         input int inject, input bit chain,
                         input logic [7:0] na, input logic [7:0] nb, input logic nc);
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            start = 1'b0;
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_done_run"}, 32'(done), 32'd0);
            check({tag, "_sum_hold"}, 32'(sum), 32'(prev_s));
            check({tag, "_cout_hold"}, 32'(c_out), 32'(prev_c));
            if (inject == i + 1) begin
                a = 8'hFF; b = 8'hFF; c_in = 1'b1; start = 1'b1;
            end
            @(posedge clk);
        end
        @(negedge clk);
        start = 1'b0;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        check({tag, "_sum"}, 32'(sum), 32'(exp_s));
        check({tag, "_cout"}, 32'(c_out), 32'(exp_c));
        if (chain) begin
            a = na; b = nb; c_in = nc; start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            check({tag, "_idle_done"}, 32'(done), 32'd0);
            check({tag, "_idle_busy"}, 32'(busy), 32'd0);
            check({tag, "_idle_sum"}, 32'(sum), 32'(exp_s));
        end
    endtask

    initial begin
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(c_out), 32'd0);
        #12 rst_n = 1'b1;

        launch(8'h00, 8'h00, 1'b0);
        track("zero", 8'h00, 1'b0, 8'h00, 1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0);

        launch(8'hFF, 8'h01, 1'b0);
        track("ff_01", 8'h00, 1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 8'h00, 1'b0);

        launch(8'hA5, 8'h5A, 1'b1);
        track("a5_5a", 8'h00, 1'b1, 8'h00, 1'b1, 0, 1'b0, 8'h00, 8'h00, 1'b0);

        launch(8'h12, 8'h34, 1'b0);
        track("ignore", 8'h00, 1'b1, 8'h46, 1'b0, 3, 1'b0, 8'h00, 8'h00, 1'b0);

        launch(8'h12, 8'h34, 1'b0);
        track("b2b_1", 8'h46, 1'b0, 8'h46, 1'b0, 0, 1'b1, 8'h7F, 8'h01, 1'b0);
        track("b2b_2", 8'h46, 1'b0, 8'h80, 1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0);

        // Abort between E3 and E4 with an asynchronous reset.
        launch(8'hFF, 8'h01, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(c_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end

        launch(8'h0F, 8'h01, 1'b0);
        track("after_rst", 8'h00, 1'b0, 8'h10, 1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder that sits directly upstream of the team's `full_adder` cell, feeding it one operand bit pair per clock and consuming its `s_out`/`c_out` results. It instantiates exactly one `full_adder` cell and closes the carry loop through a flip-flop. It trades throughput for area: one `full_adder` cell replaces a WIDTH-cell ripple chain, and a result is available WIDTH cycles after an operation is accepted. It is intended as the arithmetic core for multi-cycle datapath exercises built on the existing gate-level cells.

## Interface
- `WIDTH`, default 8: operand and sum width in bits. Must be ≥ 1.
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: request to begin an addition. Accepted only in IDLE or DONE.
- `a`, in, WIDTH: operand A, sampled on the accepting edge.
- `b`, in, WIDTH: operand B, sampled on the accepting edge.
- `c_in`, in, 1: carry-in, sampled on the accepting edge.
- `busy`, out, 1: high while in RUN.
- `done`, out, 1: one-cycle pulse; high while in DONE.
- `sum`, out, WIDTH: registered result, (a + b + c_in) mod 2^WIDTH.
- `c_out`, out, 1: registered carry-out, bit WIDTH of a + b + c_in.

## Operation
- State machine with three states: IDLE, RUN, DONE.
- IDLE:
  - `start`=1 → load the A/B shift registers from `a`/`b`, load the carry flip-flop from `c_in`, clear the bit counter, go to RUN.
  - `start`=0 → stay in IDLE.
- RUN:
  - Each cycle, the `full_adder` inputs are x = A[0], y = B[0], c_in = carry flip-flop.
  - On the edge: `s_out` shifts into the MSB of an internal sum shift register, A/B shift right, the carry flip-flop takes `c_out`, and the counter increments.
  - When the counter reaches WIDTH-1 (last bit), the same edge copies the completed sum shift register (including the current `s_out`) into `sum`, copies the final `c_out` into `c_out`, and moves to DONE.
  - `start` is ignored in RUN. Operands are not resampled.
- DONE:
  - `start`=1 → accept a new operation exactly as in IDLE and go to RUN.
  - `start`=0 → go to IDLE.
- `sum`/`c_out` change only on the completion edge. They hold the last result through IDLE, DONE and the whole next RUN.
- Counter width is $clog2(WIDTH+1). For WIDTH=1, RUN lasts exactly one cycle.
- Reset (any time, including mid-RUN):
  - state = IDLE;
  - `busy`=0, `done`=0, `sum`=0, `c_out`=0;
  - counter, carry and all shift registers = 0.
  - An aborted operation produces no `done` pulse and no result update.

## Timing
- Call the accepting edge E0.
- `busy` rises after E0 and stays high for WIDTH cycles.
- Bit k is registered on edge E(k+1), for k = 0…WIDTH-1.
- Result and DONE take effect on edge E(WIDTH): `done`=1 and `busy`=0 for the cycle following E(WIDTH).
- Latency from the accepting edge to `done`: WIDTH cycles.
- `start` held high in the DONE cycle is accepted at E(WIDTH+1). Back-to-back completions are therefore WIDTH+1 cycles apart.
- `busy` and `done` are never high together. `done` never stays high for two consecutive cycles unless WIDTH=… (never; DONE always exits after one cycle).
- Reset assertion takes effect immediately, without waiting for `clk`. After deassertion, the first `start` is sampled on the next rising edge.

## Test plan
All scenarios use WIDTH=8.
- After reset, `start` with a=0x00, b=0x00, c_in=0 → `busy` high for 8 cycles; `done` pulses at E8; `sum`=0x00, `c_out`=0.
- a=0xFF, b=0x01, c_in=0 → `sum`=0x00, `c_out`=1. `done` is high only in the cycle after E8; `sum` keeps its previous value until E8.
- a=0xA5, b=0x5A, c_in=1 → `sum`=0x00, `c_out`=1 (full carry propagation through the carry flip-flop).
- a=0x12, b=0x34, c_in=0, then `start` pulsed at E3 with a=0xFF, b=0xFF → that second request is ignored; `sum`=0x46, `c_out`=0 at E8; the FSM returns to IDLE at E9.
- Back-to-back: 0x12+0x34 accepted at E0; `start` held in the DONE cycle with a=0x7F, b=0x01, c_in=0 → `done` at E8 with `sum`=0x46, then `done` at E17 with `sum`=0x80, `c_out`=0.
- `rst_n` pulled low between E3 and E4 of a 0xFF+0x01 operation → all outputs read 0 immediately with no `done` pulse. A subsequent 0x0F+0x01 completes 8 cycles after its accepting edge with `sum`=0x10.
